pwm_timebase: RTL

Generates the shared counter and the double-buffered edge compare values consumed by the PWM `pulse` stage. It runs a free-running edge-aligned (sawtooth) or center-aligned (triangle) counter of configurable period. New period, mode and edge values are accepted through a valid/ready handshake, but take effect only at a period boundary, so a PWM cycle is never torn. Outputs connect directly to `pulse` inputs `counter`, `tick_number_rising_edge` and `tick_number_falling_edge`.

---
 rtl/pwm_timebase.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: sawtooth/triangle counter with double-buffered
// period, mode and edge compare values. Updates offered over a valid/ready
// handshake are parked in a pending buffer and only made active at a period
// boundary, so a running PWM cycle is never torn.
//
// state | meaning
// UP    | counter increments (always UP in sawtooth mode)
// DOWN  | counter decrements back toward 0 (triangle mode only)
//
// After reset the first enabled edge is a launch: the counter stays at 0
// for that edge and period_start is raised, so the very first period is
// flagged with a registered strobe like every later one.
module pwm_timebase #(
  parameter int unsigned bitwidth = 10
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                config_valid_i,
  output logic                config_ready_o,
  input  logic [bitwidth-1:0] config_period_i,
  input  logic                config_center_aligned_i,
  input  logic [bitwidth-1:0] config_rising_i,
  input  logic [bitwidth-1:0] config_falling_i,
  output logic [bitwidth-1:0] counter_o,
  output logic [bitwidth-1:0] tick_number_rising_edge_o,
  output logic [bitwidth-1:0] tick_number_falling_edge_o,
  output logic                period_start_o,
  output logic                config_applied_o
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  localparam logic [bitwidth-1:0] ONE = bitwidth'(1);

  dir_e                dir_q, dir_d;
  logic [bitwidth-1:0] cnt_q, cnt_d;
  logic [bitwidth-1:0] per_q, per_d;
  logic                mode_q, mode_d;
  logic [bitwidth-1:0] rise_q, rise_d;
  logic [bitwidth-1:0] fall_q, fall_d;
  logic [bitwidth-1:0] pper_q, pper_d;
  logic                pmode_q, pmode_d;
  logic [bitwidth-1:0] prise_q, prise_d;
  logic [bitwidth-1:0] pfall_q, pfall_d;
  logic                pvalid_q, pvalid_d;
  logic                ready_q, ready_d;
  logic                started_q, started_d;
  logic                ps_q, ps_d;
  logic                ca_q, ca_d;
  logic                boundary;
  logic                accept;

  // State register: every flop clears asynchronously, discarding any pending word.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      dir_q     <= UP;
      cnt_q     <= '0;
      per_q     <= '1;
      mode_q    <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
      pper_q    <= '0;
      pmode_q   <= 1'b0;
      prise_q   <= '0;
      pfall_q   <= '0;
      pvalid_q  <= 1'b0;
      ready_q   <= 1'b1;
      started_q <= 1'b0;
      ps_q      <= 1'b0;
      ca_q      <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      mode_q    <= mode_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pper_q    <= pper_d;
      pmode_q   <= pmode_d;
      prise_q   <= prise_d;
      pfall_q   <= pfall_d;
      pvalid_q  <= pvalid_d;
      ready_q   <= ready_d;
      started_q <= started_d;
      ps_q      <= ps_d;
      ca_q      <= ca_d;
    end
  end

  // Next state: counter stepping, boundary detection, pending apply and capture.
  always_comb begin
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    mode_d    = mode_q;
    rise_d    = rise_q;
    fall_d    = fall_q;
    pper_d    = pper_q;
    pmode_d   = pmode_q;
    prise_d   = prise_q;
    pfall_d   = pfall_q;
    pvalid_d  = pvalid_q;
    started_d = started_q;
    ps_d      = 1'b0;
    ca_d      = 1'b0;
    boundary  = 1'b0;
    accept    = config_valid_i & ready_q;

    if (enable_i) begin
      if (!started_q) begin
        started_d = 1'b1;
        ps_d      = 1'b1;
      end else if (!mode_q) begin
        dir_d = UP;
        if (cnt_q >= per_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        case (dir_q)
          UP: begin
            if (cnt_q < per_q) begin
              cnt_d = cnt_q + ONE;
            end else if (per_q <= ONE) begin
              cnt_d    = '0;
              boundary = 1'b1;
            end else begin
              cnt_d = per_q - ONE;
              dir_d = DOWN;
            end
          end
          default: begin
            if (cnt_q <= ONE) begin
              cnt_d    = '0;
              dir_d    = UP;
              boundary = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        endcase
      end

      if (boundary) begin
        ps_d = 1'b1;
        if (pvalid_q) begin
          per_d    = pper_q;
          mode_d   = pmode_q;
          rise_d   = prise_q;
          fall_d   = pfall_q;
          pvalid_d = 1'b0;
          ca_d     = 1'b1;
          dir_d    = UP;
        end
      end
    end

    // Capture only happens while the buffer is empty, so it never collides with an apply.
    if (accept) begin
      pper_d   = config_period_i;
      pmode_d  = config_center_aligned_i;
      prise_d  = config_rising_i;
      pfall_d  = config_falling_i;
      pvalid_d = 1'b1;
    end

    ready_d = ~pvalid_d;
  end

  assign config_ready_o             = ready_q;
  assign counter_o                  = cnt_q;
  assign tick_number_rising_edge_o  = rise_q;
  assign tick_number_falling_edge_o = fall_q;
  assign period_start_o             = ps_q;
  assign config_applied_o           = ca_q;

endmodule
